// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: RAM handshake state and arbiter grant state.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch and data access. Data has
// priority, a starvation counter forces fetches through, a watchdog aborts hung accesses.
module mem_port_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  output logic        arb_err,
  output arb_state_t  grant
);

  localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TCOUNT_W = $clog2(TIMEOUT);

  arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [TCOUNT_W-1:0] tcount_q, tcount_d;
  logic                arb_err_q, arb_err_d;

  logic       d_req, in_grant, complete, abort, starved;
  logic       d_elig, i_elig;
  arb_state_t pick;

  assign d_req    = dREN | dWEN;
  assign in_grant = (state_q != IDLE);
  assign complete = in_grant && (ramstate == ACCESS);
  assign abort    = in_grant && !complete &&
                    ((ramstate == ERROR) || (tcount_q == TCOUNT_W'(TIMEOUT - 1)));
  assign starved  = (streak_q == STREAK_W'(STARVE_LIMIT));

  // Arbitration pick; the requester completing this cycle steps aside.
  always_comb begin
    d_elig = d_req && !(complete && (state_q == DGRANT));
    i_elig = iREN  && !(complete && (state_q == IGRANT));
    pick   = IDLE;
    if (d_elig && i_elig) pick = starved ? IGRANT : DGRANT;
    else if (d_elig)      pick = DGRANT;
    else if (i_elig)      pick = IGRANT;
  end

  // Next state, starvation streak, watchdog and error pulse.
  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    tcount_d  = tcount_q;
    arb_err_d = 1'b0;
    if ((state_q == IDLE) || complete) begin
      state_d  = pick;
      tcount_d = '0;
      if (pick == IGRANT) begin
        streak_d = '0;
      end else if ((pick == DGRANT) && iREN && !starved) begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end else if (abort) begin
      state_d   = IDLE;
      tcount_d  = '0;
      arb_err_d = 1'b1;
    end else begin
      tcount_d = tcount_q + TCOUNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      tcount_q  <= '0;
      arb_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      tcount_q  <= tcount_d;
      arb_err_q <= arb_err_d;
    end
  end

  // RAM port mux follows the current owner; a read+write request is a write.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    unique case (state_q)
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        iload   = ramload;
      end
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN && !dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
      end
      default: ;
    endcase
  end

  assign iwait   = iREN  && !((state_q == IGRANT) && (ramstate == ACCESS));
  assign dwait   = d_req && !((state_q == DGRANT) && (ramstate == ACCESS));
  assign arb_err = arb_err_q;
  assign grant   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expectations queued per cycle and
// compared against the DUT shortly after each falling edge.
module tb_mem_port_arbiter;
  import cpu_types_pkg::*;

  localparam int S_GRANT  = 0;
  localparam int S_IWAIT  = 1;
  localparam int S_DWAIT  = 2;
  localparam int S_ILOAD  = 3;
  localparam int S_DLOAD  = 4;
  localparam int S_RREN   = 5;
  localparam int S_RWEN   = 6;
  localparam int S_RADDR  = 7;
  localparam int S_RSTORE = 8;
  localparam int S_ERR    = 9;
  localparam int S_STREAK = 10;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  ramstate_t   ramstate;
  logic        iwait, dwait, ramREN, ramWEN, arb_err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  arb_state_t  grant;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(64)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .arb_err(arb_err), .grant(grant)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_GRANT:  return 32'(grant);
      S_IWAIT:  return 32'(iwait);
      S_DWAIT:  return 32'(dwait);
      S_ILOAD:  return iload;
      S_DLOAD:  return dload;
      S_RREN:   return 32'(ramREN);
      S_RWEN:   return 32'(ramWEN);
      S_RADDR:  return ramaddr;
      S_RSTORE: return ramstore;
      S_ERR:    return 32'(arb_err);
      S_STREAK: return 32'(dut.streak_q);
      default:  return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic exp_push(input string tag, input int sel, input logic [31:0] v);
    sb.push_back('{tag, sel, v});
  endtask

  task automatic exp_grant(input string tag, input arb_state_t g);
    exp_push(tag, S_GRANT, 32'(g));
  endtask

  // Let combinational outputs settle, then drain the scoreboard.
  task automatic check_now();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic set_in(input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] ds,
                        input ramstate_t rs, input logic [31:0] rl);
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
    daddr = da; dstore = ds; ramstate = rs; ramload = rl;
  endtask

  initial begin
    RST = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, FREE, 0);

    // Reset state
    @(negedge CLK);
    exp_grant("rst_grant", IDLE);
    exp_push("rst_err", S_ERR, 0);
    exp_push("rst_rren", S_RREN, 0);
    exp_push("rst_rwen", S_RWEN, 0);
    exp_push("rst_raddr", S_RADDR, 0);
    exp_push("rst_iload", S_ILOAD, 0);
    exp_push("rst_dload", S_DLOAD, 0);
    exp_push("rst_iwait", S_IWAIT, 0);
    exp_push("rst_streak", S_STREAK, 0);
    check_now();
    @(negedge CLK);
    set_in(1, 32'h40, 0, 1, 32'h10, 0, FREE, 0);
    exp_grant("rst_grant_req", IDLE);
    exp_push("rst_iwait_follow", S_IWAIT, 1);
    exp_push("rst_dwait_follow", S_DWAIT, 1);
    check_now();
    @(negedge CLK);
    RST = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, FREE, 0);
    exp_grant("post_rst_grant", IDLE);
    check_now();

    // Lone fetch, ACCESS on the second grant cycle
    @(negedge CLK);
    set_in(1, 32'h40, 0, 0, 0, 0, FREE, 0);
    exp_grant("fetch_req_idle", IDLE);
    exp_push("fetch_req_iwait", S_IWAIT, 1);
    check_now();
    @(negedge CLK);
    ramstate = BUSY;
    exp_grant("fetch_g1", IGRANT);
    exp_push("fetch_g1_rren", S_RREN, 1);
    exp_push("fetch_g1_raddr", S_RADDR, 32'h40);
    exp_push("fetch_g1_iwait", S_IWAIT, 1);
    check_now();
    @(negedge CLK);
    ramstate = ACCESS; ramload = 32'h8C01_0004;
    exp_grant("fetch_g2", IGRANT);
    exp_push("fetch_g2_iwait", S_IWAIT, 0);
    exp_push("fetch_g2_iload", S_ILOAD, 32'h8C01_0004);
    check_now();
    @(negedge CLK);
    set_in(0, 0, 0, 0, 0, 0, FREE, 0);
    exp_grant("fetch_done_idle", IDLE);
    exp_push("fetch_done_rren", S_RREN, 0);
    exp_push("fetch_done_iload", S_ILOAD, 0);
    check_now();

    // Contention: data first, then fetch with no idle bubble
    @(negedge CLK);
    set_in(1, 32'h80, 1, 0, 32'h100, 0, FREE, 0);
    exp_grant("cont_idle", IDLE);
    exp_push("cont_iwait", S_IWAIT, 1);
    exp_push("cont_dwait", S_DWAIT, 1);
    check_now();
    @(negedge CLK);
    ramstate = ACCESS; ramload = 32'h1111_2222;
    exp_grant("cont_dgrant", DGRANT);
    exp_push("cont_d_rren", S_RREN, 1);
    exp_push("cont_d_rwen", S_RWEN, 0);
    exp_push("cont_d_raddr", S_RADDR, 32'h100);
    exp_push("cont_d_dwait", S_DWAIT, 0);
    exp_push("cont_d_dload", S_DLOAD, 32'h1111_2222);
    exp_push("cont_d_iwait", S_IWAIT, 1);
    exp_push("cont_d_streak", S_STREAK, 1);
    check_now();
    @(negedge CLK);
    dREN = 0; ramstate = BUSY;
    exp_grant("cont_igrant", IGRANT);
    exp_push("cont_i_raddr", S_RADDR, 32'h80);
    exp_push("cont_i_iwait", S_IWAIT, 1);
    exp_push("cont_i_streak", S_STREAK, 0);
    check_now();
    @(negedge CLK);
    ramstate = ACCESS; ramload = 32'h3333_4444;
    exp_push("cont_i_iwait_done", S_IWAIT, 0);
    exp_push("cont_i_iload", S_ILOAD, 32'h3333_4444);
    check_now();
    @(negedge CLK);
    set_in(0, 0, 0, 0, 0, 0, FREE, 0);
    exp_grant("cont_end_idle", IDLE);
    check_now();

    // Read+write request is treated as a write
    @(negedge CLK);
    set_in(0, 0, 1, 1, 32'h200, 32'hDEAD_BEEF, FREE, 0);
    exp_push("wr_idle_rwen", S_RWEN, 0);
    exp_push("wr_idle_dwait", S_DWAIT, 1);
    check_now();
    @(negedge CLK);
    ramstate = ACCESS;
    exp_grant("wr_dgrant", DGRANT);
    exp_push("wr_rwen", S_RWEN, 1);
    exp_push("wr_rren", S_RREN, 0);
    exp_push("wr_raddr", S_RADDR, 32'h200);
    exp_push("wr_rstore", S_RSTORE, 32'hDEAD_BEEF);
    exp_push("wr_dwait", S_DWAIT, 0);
    check_now();
    @(negedge CLK);
    set_in(0, 0, 0, 0, 0, 0, FREE, 0);
    exp_grant("wr_end_idle", IDLE);
    exp_push("wr_end_rstore", S_RSTORE, 0);
    check_now();

    // ERROR during DGRANT: abort, error pulse, implicit retry succeeds
    @(negedge CLK);
    set_in(0, 0, 1, 0, 32'h300, 0, FREE, 0);
    check_now();
    @(negedge CLK);
    ramstate = ERROR;
    exp_grant("err_dgrant", DGRANT);
    exp_push("err_dwait", S_DWAIT, 1);
    exp_push("err_pre_pulse", S_ERR, 0);
    check_now();
    @(negedge CLK);
    ramstate = FREE;
    exp_grant("err_abort_idle", IDLE);
    exp_push("err_pulse", S_ERR, 1);
    exp_push("err_dwait_held", S_DWAIT, 1);
    exp_push("err_rren_off", S_RREN, 0);
    check_now();
    @(negedge CLK);
    ramstate = ACCESS; ramload = 32'h5555_AAAA;
    exp_grant("err_regrant", DGRANT);
    exp_push("err_pulse_end", S_ERR, 0);
    exp_push("err_retry_dwait", S_DWAIT, 0);
    exp_push("err_retry_dload", S_DLOAD, 32'h5555_AAAA);
    check_now();
    @(negedge CLK);
    set_in(0, 0, 0, 0, 0, 0, FREE, 0);
    exp_grant("err_end_idle", IDLE);
    check_now();

    // Starvation: data keeps winning (and aborting) until the fetch is forced
    @(negedge CLK);
    set_in(1, 32'h44, 1, 0, 32'h400, 0, FREE, 0);
    exp_push("stv_streak0", S_STREAK, 0);
    check_now();
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      ramstate = ERROR;
      exp_grant($sformatf("stv_dgrant%0d", k), DGRANT);
      exp_push($sformatf("stv_streak%0d", k), S_STREAK, 32'(k));
      check_now();
      @(negedge CLK);
      ramstate = FREE;
      exp_grant($sformatf("stv_idle%0d", k), IDLE);
      exp_push($sformatf("stv_err%0d", k), S_ERR, 1);
      check_now();
    end
    @(negedge CLK);
    ramstate = ACCESS; ramload = 32'h0000_0077;
    exp_grant("stv_forced_igrant", IGRANT);
    exp_push("stv_streak_clr", S_STREAK, 0);
    exp_push("stv_raddr", S_RADDR, 32'h44);
    exp_push("stv_iload", S_ILOAD, 32'h0000_0077);
    exp_push("stv_dwait", S_DWAIT, 1);
    check_now();
    @(negedge CLK);
    iREN = 0; ramstate = ACCESS;
    exp_grant("stv_handoff_d", DGRANT);
    exp_push("stv_handoff_dwait", S_DWAIT, 0);
    check_now();
    @(negedge CLK);
    set_in(0, 0, 0, 0, 0, 0, FREE, 0);
    exp_grant("stv_end_idle", IDLE);
    check_now();

    // Watchdog: BUSY forever aborts after 64 grant cycles
    @(negedge CLK);
    set_in(0, 0, 1, 0, 32'h500, 0, BUSY, 0);
    check_now();
    for (int c = 1; c <= 64; c++) begin
      @(negedge CLK);
      exp_grant($sformatf("to_busy_c%0d", c), DGRANT);
      check_now();
    end
    @(negedge CLK);
    exp_grant("to_abort_idle", IDLE);
    exp_push("to_err", S_ERR, 1);
    exp_push("to_dwait", S_DWAIT, 1);
    check_now();
    // Re-grant; ERROR coinciding with timeout gives one pulse
    for (int c = 1; c <= 64; c++) begin
      @(negedge CLK);
      ramstate = (c == 64) ? ERROR : BUSY;
      exp_grant($sformatf("to2_c%0d", c), DGRANT);
      exp_push($sformatf("to2_err_c%0d", c), S_ERR, 0);
      check_now();
    end
    @(negedge CLK);
    ramstate = FREE;
    exp_grant("to2_abort_idle", IDLE);
    exp_push("to2_err", S_ERR, 1);
    check_now();
    @(negedge CLK);
    ramstate = ACCESS;
    exp_grant("to2_regrant", DGRANT);
    exp_push("to2_err_single", S_ERR, 0);
    exp_push("to2_dwait_done", S_DWAIT, 0);
    check_now();
    @(negedge CLK);
    set_in(0, 0, 0, 0, 0, 0, FREE, 0);
    exp_grant("to_end_idle", IDLE);
    check_now();

    // Reset in the middle of a fetch grant
    @(negedge CLK);
    set_in(1, 32'h600, 0, 0, 0, 0, FREE, 0);
    check_now();
    @(negedge CLK);
    ramstate = BUSY; RST = 1'b1;
    exp_grant("rmid_igrant", IGRANT);
    exp_push("rmid_rren_on", S_RREN, 1);
    check_now();
    @(negedge CLK);
    RST = 1'b0;
    exp_grant("rmid_idle", IDLE);
    exp_push("rmid_rren_off", S_RREN, 0);
    exp_push("rmid_streak", S_STREAK, 0);
    exp_push("rmid_iwait", S_IWAIT, 1);
    check_now();
    @(negedge CLK);
    set_in(0, 0, 0, 0, 0, 0, FREE, 0);
    check_now();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
